// File: rtl/multicycle_control.sv
// Control sequencer for the multicycle datapath: steps each instruction through
// fetch/decode/execute/memory/write-back with a timed req/ack memory interface.
module multicycle_control #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ADIU = 6'b001001;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
    EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, TRAP
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       fault;
  } ctl_t;

  state_t     state;
  logic [CNT_W-1:0] wait_cnt;
  ctl_t       ctl, ctl_o;
  logic       in_req, timed_out;

  // zero only feeds the datapath's pc_en; the sequencer never branches on it
  logic unused_zero;
  assign unused_zero = zero;

  assign in_req    = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT)) && !mem_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      wait_cnt    <= '0;
      instr_count <= '0;
    end else begin
      wait_cnt <= (in_req && !mem_ack) ? wait_cnt + 1'b1 : '0;
      case (state)
        FETCH: begin
          if (mem_ack)        state <= DECODE;
          else if (timed_out) state <= TRAP;
        end
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW:     state <= MEM_ADDR;
            OP_R:             state <= EXEC_R;
            OP_BEQ:           state <= BRANCH;
            OP_J:             state <= JUMP;
            OP_ADDI, OP_ADIU: state <= EXEC_I;
            default:          state <= TRAP;
          endcase
        end
        MEM_ADDR: state <= (opcode == OP_SW) ? MEM_WR : MEM_RD;
        MEM_RD: begin
          if (mem_ack)        state <= MEM_WB;
          else if (timed_out) state <= TRAP;
        end
        MEM_WR: begin
          if (mem_ack) begin
            state       <= FETCH;
            instr_count <= instr_count + 1'b1;
          end else if (timed_out) begin
            state <= TRAP;
          end
        end
        EXEC_R: state <= R_WB;
        EXEC_I: state <= I_WB;
        MEM_WB, R_WB, I_WB, BRANCH, JUMP: begin
          state       <= FETCH;
          instr_count <= instr_count + 1'b1;
        end
        default: state <= TRAP;
      endcase
    end
  end

  always_comb begin
    ctl = '0;
    case (state)
      FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'b01;
        ctl.ir_write  = mem_ack;
        ctl.pc_write  = mem_ack;
      end
      DECODE:   ctl.alu_src_b = 2'b11;
      MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
      end
      MEM_RD: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        ctl.mem_write = 1'b1;
        ctl.i_or_d    = 1'b1;
      end
      EXEC_R: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = 4'b1000;
      end
      R_WB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
      end
      EXEC_I: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
      end
      I_WB:   ctl.reg_write = 1'b1;
      BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_op        = 4'b0001;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = 2'b01;
      end
      JUMP: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = 2'b10;
      end
      TRAP:    ctl.fault = 1'b1;
      default: ctl = '0;
    endcase
  end

  // outputs are forced low while reset is held, so no request leaks out of FETCH
  assign ctl_o = reset ? ctl : '0;

  assign pc_write      = ctl_o.pc_write;
  assign pc_write_cond = ctl_o.pc_write_cond;
  assign pc_source     = ctl_o.pc_source;
  assign i_or_d        = ctl_o.i_or_d;
  assign mem_read      = ctl_o.mem_read;
  assign mem_write     = ctl_o.mem_write;
  assign ir_write      = ctl_o.ir_write;
  assign reg_dst       = ctl_o.reg_dst;
  assign mem_to_reg    = ctl_o.mem_to_reg;
  assign reg_write     = ctl_o.reg_write;
  assign alu_src_a     = ctl_o.alu_src_a;
  assign alu_src_b     = ctl_o.alu_src_b;
  assign alu_op        = ctl_o.alu_op;
  assign fault         = ctl_o.fault;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: instruction-level schedules expand into per-cycle expected
// control words; a negedge monitor pops and compares them.
module tb_multicycle_control;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ack;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, fault;
  logic [1:0] pc_source, alu_src_b;
  logic [3:0] alu_op;
  logic [7:0] instr_count;

  multicycle_control #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .fault(fault), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef enum {K_RST, K_FETCH, K_DECODE, K_MADDR, K_MRD, K_MWB, K_MWR,
                K_EXR, K_RWB, K_EXI, K_IWB, K_BR, K_J, K_TRAP} kind_e;
  typedef struct {
    logic [18:0] w;
    logic [7:0]  cnt;
    kind_e       k;
  } exp_t;

  exp_t       sb[$];
  int         total = 0, bad = 0;
  logic [7:0] mcnt = 8'd0;
  logic [5:0] legal [7] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h02, 6'h08, 6'h09};

  // Control word for one cycle of a given phase, straight from the phase table
  function automatic logic [18:0] exp_word(kind_e k, logic ack);
    logic pw = 0, pwc = 0, iod = 0, mr = 0, mw = 0, irw = 0, rd = 0;
    logic m2r = 0, rw = 0, asa = 0, flt = 0;
    logic [1:0] ps = 0, asb = 0;
    logic [3:0] op = 0;
    case (k)
      K_FETCH:  begin mr = 1; asb = 2'b01; pw = ack; irw = ack; end
      K_DECODE: asb = 2'b11;
      K_MADDR:  begin asa = 1; asb = 2'b10; end
      K_MRD:    begin mr = 1; iod = 1; end
      K_MWB:    begin rw = 1; m2r = 1; end
      K_MWR:    begin mw = 1; iod = 1; end
      K_EXR:    begin asa = 1; op = 4'b1000; end
      K_RWB:    begin rw = 1; rd = 1; end
      K_EXI:    begin asa = 1; asb = 2'b10; end
      K_IWB:    rw = 1;
      K_BR:     begin asa = 1; op = 4'b0001; pwc = 1; ps = 2'b01; end
      K_J:      begin pw = 1; ps = 2'b10; end
      K_TRAP:   flt = 1;
      default:  ;
    endcase
    return {pw, pwc, ps, iod, mr, mw, irw, rd, m2r, rw, asa, asb, op, flt};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: drive inputs, queue the expected response, advance.
  task automatic step(kind_e k, logic [5:0] op, logic ack, bit retire);
    exp_t e;
    reset   = (k != K_RST);
    opcode  = op;
    mem_ack = ack;
    zero    = rbit();
    if (k == K_RST) mcnt = 8'd0;
    e.w   = exp_word(k, ack);
    e.cnt = mcnt;
    e.k   = k;
    sb.push_back(e);
    if (retire) mcnt = mcnt + 8'd1;
    @(posedge clk);
    #1;
  endtask

  // A memory request waiting w cycles; w > TO means it never gets acked.
  task automatic req(kind_e k, logic [5:0] op, int w, bit ret_on_ack, output bit ok);
    int n;
    n  = (w > TO) ? TO + 1 : w;
    ok = (w <= TO);
    for (int i = 0; i < n; i++) step(k, (k == K_FETCH) ? 6'($urandom) : op, 1'b0, 1'b0);
    if (ok) step(k, (k == K_FETCH) ? 6'($urandom) : op, 1'b1, ret_on_ack);
  endtask

  task automatic trap_out();
    int n;
    n = 2 + int'($urandom_range(0, 3));
    for (int i = 0; i < n; i++) step(K_TRAP, 6'($urandom), rbit(), 1'b0);
    step(K_RST, 6'($urandom), rbit(), 1'b0);
  endtask

  task automatic do_instr(logic [5:0] op, int wf, int wm);
    bit ok;
    req(K_FETCH, op, wf, 1'b0, ok);
    if (!ok) begin trap_out(); return; end
    step(K_DECODE, op, rbit(), 1'b0);
    case (op)
      6'h23: begin
        step(K_MADDR, op, rbit(), 1'b0);
        req(K_MRD, op, wm, 1'b0, ok);
        if (!ok) begin trap_out(); return; end
        step(K_MWB, op, rbit(), 1'b1);
      end
      6'h2b: begin
        step(K_MADDR, op, rbit(), 1'b0);
        req(K_MWR, op, wm, 1'b1, ok);
        if (!ok) begin trap_out(); return; end
      end
      6'h00: begin step(K_EXR, op, rbit(), 1'b0); step(K_RWB, op, rbit(), 1'b1); end
      6'h04: step(K_BR, op, rbit(), 1'b1);
      6'h02: step(K_J, op, rbit(), 1'b1);
      6'h08, 6'h09: begin step(K_EXI, op, rbit(), 1'b0); step(K_IWB, op, rbit(), 1'b1); end
      default: trap_out();
    endcase
  endtask

  function automatic int rwait();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return TO + 1;
    if (r == 1) return TO;
    return int'($urandom_range(0, 2));
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    logic [18:0] got;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, fault};
      total++;
      if (got !== e.w || instr_count !== e.cnt) begin
        bad++;
        $display("FAIL %s: got ctl=%05h cnt=%0d, want ctl=%05h cnt=%0d",
                 e.k.name(), got, instr_count, e.w, e.cnt);
      end
    end
  end

  initial begin
    logic [5:0] op;
    reset = 1'b1; zero = 1'b0; mem_ack = 1'b0; opcode = '0;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    step(K_RST, 6'h00, 1'b1, 1'b0);
    step(K_RST, 6'h00, 1'b0, 1'b0);

    do_instr(6'h23, 0, 0);            // lw, zero wait
    do_instr(6'h04, 0, 0);            // beq twice
    do_instr(6'h04, 0, 0);
    do_instr(6'h2b, 0, 3);            // sw, 3 wait cycles
    do_instr(6'h00, 1, 0);
    do_instr(6'h08, 0, 0);
    do_instr(6'h09, TO, 0);           // fetch ack exactly at the limit
    do_instr(6'h23, 0, TO);           // read ack exactly at the limit
    do_instr(6'h2b, 0, TO);
    do_instr(6'h02, TO + 1, 0);       // fetch timeout
    do_instr(6'h3f, 0, 0);            // illegal opcode
    do_instr(6'h23, 1, TO + 1);       // read timeout
    do_instr(6'h2b, 0, TO + 1);       // write timeout
    do_instr(6'h00, 0, 0);

    // reset in the middle of a store wait
    step(K_FETCH, 6'h11, 1'b1, 1'b0);
    step(K_DECODE, 6'h2b, 1'b0, 1'b0);
    step(K_MADDR, 6'h2b, 1'b1, 1'b0);
    step(K_MWR, 6'h2b, 1'b0, 1'b0);
    step(K_MWR, 6'h2b, 1'b0, 1'b0);
    step(K_RST, 6'h2b, 1'b1, 1'b0);

    for (int i = 0; i < 260; i++) do_instr(6'h02, 0, 0);   // counter wrap

    for (int i = 0; i < 200; i++) begin
      int r;
      r  = int'($urandom_range(0, 9));
      op = (r < 7) ? legal[r] : 6'($urandom);
      do_instr(op, rwait(), rwait());
    end

    step(K_RST, 6'h00, 1'b0, 1'b0);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected entries left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
